// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control unit: beat indices, the opcode
// enum, control-word bit positions and the fetch-phase control words.
package ctrl_pkg;

  localparam int N_BEATS = 8;

  localparam logic [2:0] B_T0 = 3'd0;
  localparam logic [2:0] B_T1 = 3'd1;
  localparam logic [2:0] B_T2 = 3'd2;
  localparam logic [2:0] B_T3 = 3'd3;
  localparam logic [2:0] B_T4 = 3'd4;
  localparam logic [2:0] B_T5 = 3'd5;
  localparam logic [2:0] B_T6 = 3'd6;

  typedef enum logic [3:0] {
    OP_NONE, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_HALT
  } op_e;

  localparam int CW_W    = 14;
  localparam int CW_IMAR = 0;
  localparam int CW_IPC  = 1;
  localparam int CW_IDR  = 2;
  localparam int CW_EDR  = 3;
  localparam int CW_IA   = 4;
  localparam int CW_EA   = 5;
  localparam int CW_ISUM = 6;
  localparam int CW_ISUB = 7;
  localparam int CW_IAND = 8;
  localparam int CW_IOR  = 9;
  localparam int CW_IXOR = 10;
  localparam int CW_ISHL = 11;
  localparam int CW_EALU = 12;
  localparam int CW_IIR  = 13;

  typedef logic [CW_W-1:0] cw_t;

  function automatic cw_t strobe(int pos);
    return cw_t'(1) << pos;
  endfunction

  // Instruction fetch is common to every opcode, so it is keyed on beat only.
  function automatic cw_t fetch_cw(logic [2:0] beat);
    case (beat)
      B_T0:    return strobe(CW_IMAR);
      B_T1:    return strobe(CW_IDR) | strobe(CW_IPC);
      B_T2:    return strobe(CW_EDR) | strobe(CW_IIR);
      default: return '0;
    endcase
  endfunction

  function automatic cw_t alu_sel(op_e op);
    case (op)
      OP_ADD:  return strobe(CW_ISUM);
      OP_SUB:  return strobe(CW_ISUB);
      OP_AND:  return strobe(CW_IAND);
      OP_OR:   return strobe(CW_IOR);
      OP_XOR:  return strobe(CW_IXOR);
      OP_SHL:  return strobe(CW_ISHL);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Opcode lines, beat pulses and datapath strobes of the control unit.
// The master side drives opcode/beat lines; the slave (control unit) drives strobes.
interface control_unit_if;
  logic LD, ADD, SUB, AND, OR, XOR, SHL, HALT;
  logic T0, T1, T2, T3, T4, T5, T6, T7;
  logic IMAR, IPC, IDR, EDR, IA, EA;
  logic ISUM, ISUB, IAND, IOR, IXOR, ISHL;
  logic EALU, IIR;
  logic halted, err;

  modport master (
    output LD, ADD, SUB, AND, OR, XOR, SHL, HALT,
    output T0, T1, T2, T3, T4, T5, T6, T7,
    input  IMAR, IPC, IDR, EDR, IA, EA, ISUM, ISUB, IAND, IOR, IXOR, ISHL,
    input  EALU, IIR, halted, err
  );

  modport slave (
    input  LD, ADD, SUB, AND, OR, XOR, SHL, HALT,
    input  T0, T1, T2, T3, T4, T5, T6, T7,
    output IMAR, IPC, IDR, EDR, IA, EA, ISUM, ISUB, IAND, IOR, IXOR, ISHL,
    output EALU, IIR, halted, err
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational decode of (active beat, winning opcode) into the
// 14-bit control word. EA is never produced by the current opcode set.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       beat_vld,
  input  logic [2:0] beat,
  input  op_e        op,
  output cw_t        cw
);

  always_comb begin
    cw = '0;
    if (beat_vld) begin
      if (beat <= B_T2) begin
        cw = fetch_cw(beat);
      end else begin
        case (op)
          OP_LD: begin
            case (beat)
              B_T3:    cw = strobe(CW_IMAR);
              B_T4:    cw = strobe(CW_IDR) | strobe(CW_IPC);
              B_T5:    cw = strobe(CW_EDR) | strobe(CW_IA);
              default: cw = '0;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
            case (beat)
              B_T3:    cw = strobe(CW_IMAR);
              B_T4:    cw = strobe(CW_IDR) | strobe(CW_IPC);
              B_T5:    cw = strobe(CW_EDR) | alu_sel(op);
              B_T6:    cw = strobe(CW_EALU) | strobe(CW_IA);
              default: cw = '0;
            endcase
          end
          default: cw = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: registered strobes one clock after the beat/opcode
// inputs, sticky halt. Optional input checker enabled by CTRL_ONEHOT_CHK_EN.
module control_unit
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  bus
);

  logic [N_BEATS-1:0] t;
  logic [7:0]         ops;
  logic               beat_vld;
  logic [2:0]         beat;
  op_e                op;
  cw_t                cw;
  cw_t                cw_q;
  logic               halted_q;
  logic               illegal;
  logic               halt_hit;

  assign t   = {bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1, bus.T0};
  assign ops = {bus.HALT, bus.SHL, bus.XOR, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.LD};

  // Scan downward so the lowest-numbered active beat is the last assignment.
  always_comb begin
    beat_vld = 1'b0;
    beat     = '0;
    for (int i = N_BEATS - 1; i >= 0; i--) begin
      if (t[i]) begin
        beat_vld = 1'b1;
        beat     = 3'(i);
      end
    end
  end

  always_comb begin
    op = OP_NONE;
    if      (bus.HALT) op = OP_HALT;
    else if (bus.LD)   op = OP_LD;
    else if (bus.ADD)  op = OP_ADD;
    else if (bus.SUB)  op = OP_SUB;
    else if (bus.AND)  op = OP_AND;
    else if (bus.OR)   op = OP_OR;
    else if (bus.XOR)  op = OP_XOR;
    else if (bus.SHL)  op = OP_SHL;
  end

  ctrl_decode u_decode (
    .beat_vld (beat_vld),
    .beat     (beat),
    .op       (op),
    .cw       (cw)
  );

`ifdef CTRL_ONEHOT_CHK_EN
  logic err_q;

  // Beat index is only meaningful when T is one-hot, which the first term covers.
  assign illegal = !$onehot(t) || (($countones(ops) > 1) && (beat >= B_T3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign illegal = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign halt_hit = beat_vld && (beat == B_T3) && (op == OP_HALT) && !illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      cw_q <= (halted_q || illegal) ? '0 : cw;
      if (halt_hit) halted_q <= 1'b1;
    end
  end

  assign bus.IMAR   = cw_q[CW_IMAR];
  assign bus.IPC    = cw_q[CW_IPC];
  assign bus.IDR    = cw_q[CW_IDR];
  assign bus.EDR    = cw_q[CW_EDR];
  assign bus.IA     = cw_q[CW_IA];
  assign bus.EA     = cw_q[CW_EA];
  assign bus.ISUM   = cw_q[CW_ISUM];
  assign bus.ISUB   = cw_q[CW_ISUB];
  assign bus.IAND   = cw_q[CW_IAND];
  assign bus.IOR    = cw_q[CW_IOR];
  assign bus.IXOR   = cw_q[CW_IXOR];
  assign bus.ISHL   = cw_q[CW_ISHL];
  assign bus.EALU   = cw_q[CW_EALU];
  assign bus.IIR    = cw_q[CW_IIR];
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction sequences plus randomized
// beat/opcode stimulus checked through an expected-value queue.
module tb_control_unit;

  // Opcode vector order used throughout the bench
  localparam int O_LD = 0, O_ADD = 1, O_SUB = 2, O_AND = 3, O_OR = 4, O_XOR = 5, O_SHL = 6, O_HALT = 7;
  // Observed word order: 14 strobes, then halted, then err
  localparam int S_IMAR = 0, S_IPC = 1, S_IDR = 2, S_EDR = 3, S_IA = 4, S_EA = 5;
  localparam int S_SEL0 = 6, S_EALU = 12, S_IIR = 13, S_HALTED = 14, S_ERR = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];
  logic        m_halted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [15:0] observed();
    return {bus.err, bus.halted, bus.IIR, bus.EALU, bus.ISHL, bus.IXOR, bus.IOR,
            bus.IAND, bus.ISUB, bus.ISUM, bus.EA, bus.IA, bus.EDR, bus.IDR, bus.IPC, bus.IMAR};
  endfunction

  // Reference: one instruction = fetch on T0..T2, operand fetch on T3..T4,
  // then load (LD) or ALU select on T5 and ALU write-back on T6.
  function automatic logic [15:0] model(logic [7:0] t, logic [7:0] ops, inout logic hlt);
    logic [15:0] w;
    int beat;
    int win;
    int prio[8];
    bit is_alu;
    w = '0;
    if (hlt) begin
      w[S_HALTED] = 1'b1;
      return w;
    end
    beat = -1;
    for (int i = 7; i >= 0; i--) if (t[i]) beat = i;
    prio = '{O_HALT, O_LD, O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_SHL};
    win = -1;
    for (int i = 7; i >= 0; i--) if (ops[prio[i]]) win = prio[i];
    is_alu = (win >= O_ADD) && (win <= O_SHL);
    case (beat)
      0: w[S_IMAR] = 1'b1;
      1: begin w[S_IDR] = 1'b1; w[S_IPC] = 1'b1; end
      2: begin w[S_EDR] = 1'b1; w[S_IIR] = 1'b1; end
      3: begin
        if (win == O_LD || is_alu) w[S_IMAR] = 1'b1;
        if (win == O_HALT) hlt = 1'b1;
      end
      4: if (win == O_LD || is_alu) begin w[S_IDR] = 1'b1; w[S_IPC] = 1'b1; end
      5: begin
        if (win == O_LD) begin w[S_EDR] = 1'b1; w[S_IA] = 1'b1; end
        if (is_alu) begin w[S_EDR] = 1'b1; w[S_SEL0 + win - O_ADD] = 1'b1; end
      end
      6: if (is_alu) begin w[S_EALU] = 1'b1; w[S_IA] = 1'b1; end
      default: ;
    endcase
    w[S_HALTED] = hlt;
    return w;
  endfunction

  task automatic set_lines(logic [7:0] t, logic [7:0] ops);
    {bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1, bus.T0} = t;
    {bus.HALT, bus.SHL, bus.XOR, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.LD} = ops;
  endtask

  task automatic apply(logic [7:0] t, logic [7:0] ops);
    logic [15:0] e;
    @(posedge clk);
    #1;
    set_lines(t, ops);
    e = model(t, ops, m_halted);
    exp_q.push_back(e);
    due_q.push_back(cyc);
  endtask

  task automatic run_instr(logic [7:0] ops, bit rand_hold);
    logic [7:0] t;
    for (int b = 0; b < 8; b++) begin
      t = 8'b1 << b;
      apply(t, ops);
      if (rand_hold && $urandom_range(0, 3) == 0) apply(t, ops);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async", observed(), 16'h0000);
    exp_q.delete();
    due_q.delete();
    m_halted = 1'b0;
    set_lines(8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: an entry becomes checkable once the edge after its drive has passed.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0 && due_q[0] < cyc) begin
      check("strobes", observed(), exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  initial begin
    logic [7:0] ops;
    logic [7:0] t;
    set_lines(8'h00, 8'h00);
    #2;
    check("reset_state", observed(), 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr(8'b1 << O_LD, 1'b0);
    run_instr(8'b1 << O_ADD, 1'b0);
    run_instr(8'b1 << O_SUB, 1'b0);
    for (int o = O_AND; o <= O_SHL; o++) run_instr(8'b1 << o, 1'b0);
    run_instr((8'b1 << O_ADD) | (8'b1 << O_SUB), 1'b0);
    apply(8'h00, 8'b1 << O_LD);
    apply(8'b0011_0000, 8'b1 << O_ADD);
    apply(8'b0110_0000, (8'b1 << O_LD) | (8'b1 << O_SHL));
    apply(8'b1000_1000, 8'b1 << O_XOR);

    // Reset in the middle of an instruction
    apply(8'b1 << 1, 8'b1 << O_LD);
    apply(8'b1 << 2, 8'b1 << O_LD);
    pulse_reset();

    run_instr(8'b1 << O_HALT, 1'b0);
    run_instr(8'b1 << O_LD, 1'b0);
    run_instr(8'b1 << O_ADD, 1'b1);
    pulse_reset();
    check("halt_cleared", {15'h0, bus.halted}, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) ops = 8'($urandom_range(0, 255));
      else ops = 8'b1 << $urandom_range(0, 6);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 4; k++) begin
          t = 8'($urandom_range(0, 255));
          apply(t, ops);
        end
      end else begin
        run_instr(ops, 1'b1);
      end
    end

    run_instr(8'b1 << O_HALT, 1'b1);
    run_instr(8'b1 << O_SUB, 1'b1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #6;
    check("drain", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
